alu_operand_sequencer: RTL and testbench

Multi-cycle operand-fetch and writeback controller that sits directly upstream and downstream of the 16-bit ALU (ADD/SUB/AND/NOT, Z flag).
- Owns an 8-entry register file with a single read port.
- Loads operands A and B over successive cycles, presents them with the opcode to the ALU, captures the ALU result into C and Z into a status register, then writes C back to a destination register.
- A host port preloads registers and launches operations.

---
 rtl/alu_operand_sequencer_pkg.sv | 23 ++
 rtl/alu_operand_sequencer_reg_file.sv | 31 +++
 rtl/alu_operand_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types for the ALU operand sequencer: opcode and sequencer state enums,
// plus default datapath dimensions.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREGS_DEF  = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WRITE
    } seq_state_e;

endpackage

// File: rtl/alu_operand_sequencer_reg_file.sv
// NREGS x DATA_W register file: one combinational read port, one synchronous
// write port, asynchronous clear. Same-edge read returns the pre-write value.
module reg_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    assign rdata = regs_q[raddr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand-fetch / writeback controller around an external 16-bit ALU.
// Optional macro ALU_SKIP_B_EN: NOT skips the LOAD_B fetch (3-cycle latency).
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     rd_a_num,
    input  logic [AW-1:0]     rd_b_num,
    input  logic [AW-1:0]     wr_num,
    input  logic [1:0]        op,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_wnum,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_wr_ok,
    output logic [DATA_W-1:0] val_A,
    output logic [DATA_W-1:0] val_B,
    output logic [1:0]        ALU_op,
    input  logic [DATA_W-1:0] ALU_out,
    input  logic              Z,
    output logic [DATA_W-1:0] C,
    output logic              Z_flag,
    output logic              busy,
    output logic              done
);

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     a_num_q, a_num_d;
    logic [AW-1:0]     b_num_q, b_num_d;
    logic [AW-1:0]     wr_num_q, wr_num_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic              z_q, z_d;

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [AW-1:0]     rf_raddr;
    logic [DATA_W-1:0] rf_rdata;

    always_comb begin
        state_d  = state_q;
        a_num_d  = a_num_q;
        b_num_d  = b_num_q;
        wr_num_d = wr_num_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        z_d      = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_num_d  = rd_a_num;
                    b_num_d  = rd_b_num;
                    wr_num_d = wr_num;
                    op_d     = op;
                    state_d  = LOAD_A;
                end
            end
            LOAD_A: begin
                a_d = rf_rdata;
`ifdef ALU_SKIP_B_EN
                // NOT ignores B, so its fetch cycle is skipped and B is left as-is.
                state_d = (op_q == 2'(ALU_NOT)) ? EXEC : LOAD_B;
`else
                state_d = LOAD_B;
`endif
            end
            LOAD_B: begin
                b_d     = rf_rdata;
                state_d = EXEC;
            end
            EXEC: begin
                c_d     = ALU_out;
                z_d     = Z;
                state_d = WRITE;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_num_q  <= '0;
            b_num_q  <= '0;
            wr_num_q <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_num_q  <= a_num_d;
            b_num_q  <= b_num_d;
            wr_num_q <= wr_num_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            z_q      <= z_d;
        end
    end

    // Writeback owns the single write port in WRITE; host writes are dropped then.
    always_comb begin
        rf_we    = ext_we;
        rf_waddr = ext_wnum;
        rf_wdata = ext_wdata;
        if (state_q == WRITE) begin
            rf_we    = 1'b1;
            rf_waddr = wr_num_q;
            rf_wdata = c_q;
        end
    end

    assign rf_raddr = (state_q == LOAD_B) ? b_num_q : a_num_q;

    reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    assign val_A     = a_q;
    assign val_B     = b_q;
    assign ALU_op    = op_q;
    assign C         = c_q;
    assign Z_flag    = z_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == WRITE);
    assign ext_wr_ok = (state_q != WRITE);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a latency-indexed reference model
// and a behavioural ALU closing the loop.
module tb_alu_operand_sequencer;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
`ifdef ALU_SKIP_B_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rd_a_num, rd_b_num, wr_num, ext_wnum;
    logic [1:0]    op;
    logic          ext_we;
    logic [DW-1:0] ext_wdata;
    logic          ext_wr_ok;
    logic [DW-1:0] val_A, val_B, ALU_out, C;
    logic [1:0]    ALU_op;
    logic          Z, Z_flag, busy, done;

    always #5 clk = ~clk;

    alu_operand_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_a_num(rd_a_num), .rd_b_num(rd_b_num), .wr_num(wr_num), .op(op),
        .ext_we(ext_we), .ext_wnum(ext_wnum), .ext_wdata(ext_wdata), .ext_wr_ok(ext_wr_ok),
        .val_A(val_A), .val_B(val_B), .ALU_op(ALU_op), .ALU_out(ALU_out), .Z(Z),
        .C(C), .Z_flag(Z_flag), .busy(busy), .done(done)
    );

    function automatic logic [DW-1:0] alu_f(input logic [1:0] o, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (o)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~a;
        endcase
    endfunction

    assign ALU_out = alu_f(ALU_op, val_A, val_B);
    assign Z       = (ALU_out == '0);

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Model: an accepted start opens an operation indexed by edges since acceptance.
    // A is fetched at edge 1, B at edge 2 (unless skipped), result at wb-1, writeback at wb.
    logic [DW-1:0] mregs [NR];
    logic [DW-1:0] m_a, m_b, m_c;
    logic          m_z;
    logic [1:0]    m_op;
    logic [AW-1:0] ma, mb, mw;
    int            since;
    int            wb;

    always @(posedge clk or negedge rst_n) begin
        int e;
        logic host_ok;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) mregs[i] = '0;
            m_a = '0; m_b = '0; m_c = '0; m_z = 1'b0; m_op = '0;
            ma = '0; mb = '0; mw = '0;
            since = -1; wb = 4;
        end else begin
            host_ok = !(since >= 0 && since + 1 == wb);
            if (since >= 0) begin
                e = since + 1;
                if (e == 1) m_a = mregs[ma];
                if (e == 2 && wb == 4) m_b = mregs[mb];
                if (e == wb - 1) begin
                    m_c = alu_f(m_op, m_a, m_b);
                    m_z = (m_c == '0);
                end
                if (e == wb) begin
                    mregs[mw] = m_c;
                    since = -1;
                end else begin
                    since = e;
                end
            end else if (start) begin
                ma = rd_a_num; mb = rd_b_num; mw = wr_num; m_op = op;
                wb = (SKIP && op == 2'b11) ? 3 : 4;
                since = 0;
            end
            if (ext_we && host_ok) mregs[ext_wnum] = ext_wdata;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 32'(busy), 32'(since >= 0));
            check("done", 32'(done), 32'(since >= 0 && since == wb - 1));
            check("ext_wr_ok", 32'(ext_wr_ok), 32'(!(since >= 0 && since == wb - 1)));
            check("val_A", 32'(val_A), 32'(m_a));
            check("val_B", 32'(val_B), 32'(m_b));
            check("ALU_op", 32'(ALU_op), 32'(m_op));
            check("C", 32'(C), 32'(m_c));
            check("Z_flag", 32'(Z_flag), 32'(m_z));
            for (int i = 0; i < NR; i++)
                check($sformatf("R%0d", i), 32'(dut.u_rf.regs_q[i]), 32'(mregs[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic host(input logic [AW-1:0] n, input logic [DW-1:0] d);
        ext_we = 1'b1; ext_wnum = n; ext_wdata = d;
        tick();
        ext_we = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    // Launch and return in the WRITE cycle; n = edges after the accepting edge.
    task automatic run_op(input logic [1:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] w, output int n);
        op = o; rd_a_num = a; rd_b_num = b; wr_num = w; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; op = '0; rd_a_num = '0; rd_b_num = '0; wr_num = '0;
        ext_we = 1'b0; ext_wnum = '0; ext_wdata = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ext_wr_ok", 32'(ext_wr_ok), 32'd1);
        check("rst_C", 32'(C), 32'd0);
        rst_n = 1'b1;
        tick();

        // 13 - 4 -> R3
        host(3'd1, 16'd13);
        host(3'd2, 16'd4);
        run_op(2'b01, 3'd1, 3'd2, 3'd3, n);
        check("sub_latency", 32'(n), 32'd3);
        check("sub_val_A", 32'(val_A), 32'd13);
        check("sub_val_B", 32'(val_B), 32'd4);
        check("sub_C", 32'(C), 32'd9);
        check("sub_Z", 32'(Z_flag), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        check("R3_wb", 32'(dut.u_rf.regs_q[3]), 32'd9);

        // 10 - 11 wraps; 0 + 0 sets Z
        host(3'd1, 16'd10);
        host(3'd2, 16'd11);
        run_op(2'b01, 3'd1, 3'd2, 3'd5, n);
        check("wrap_C", 32'(C), 32'h0000ffff);
        check("wrap_Z", 32'(Z_flag), 32'd0);
        tick();
        run_op(2'b00, 3'd0, 3'd0, 3'd6, n);
        check("zero_C", 32'(C), 32'd0);
        check("zero_Z", 32'(Z_flag), 32'd1);
        tick();
        check("R5_wb", 32'(dut.u_rf.regs_q[5]), 32'h0000ffff);

        // start pulsed during LOAD_B is ignored
        op = 2'b01; rd_a_num = 3'd1; rd_b_num = 3'd2; wr_num = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op = 2'b00; rd_a_num = 3'd0; rd_b_num = 3'd0; wr_num = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        wait_done(n);
        check("ign_C", 32'(C), 32'h0000ffff);
        check("ign_op", 32'(ALU_op), 32'd1);
        tick();
        check("ign_R3", 32'(dut.u_rf.regs_q[3]), 32'h0000ffff);
        tick();
        check("ign_idle", 32'(busy), 32'd0);

        // host write dropped in WRITE, accepted in IDLE
        run_op(2'b00, 3'd1, 3'd2, 3'd6, n);
        ext_we = 1'b1; ext_wnum = 3'd4; ext_wdata = 16'h1234;
        check("wr_ok_low", 32'(ext_wr_ok), 32'd0);
        tick();
        ext_we = 1'b0;
        check("R4_dropped", 32'(dut.u_rf.regs_q[4]), 32'd0);
        check("R6_wb", 32'(dut.u_rf.regs_q[6]), 32'd21);
        host(3'd4, 16'h1234);
        check("R4_idle", 32'(dut.u_rf.regs_q[4]), 32'h00001234);

        // reset during EXEC aborts the write to R7
        op = 2'b00; rd_a_num = 3'd1; rd_b_num = 3'd2; wr_num = 3'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_C", 32'(C), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_R7", 32'(dut.u_rf.regs_q[7]), 32'd0);
        check("abort_done", 32'(done), 32'd0);

        // NOT R2 -> R2, source == destination
        host(3'd2, 16'd4);
        run_op(2'b11, 3'd2, 3'd0, 3'd2, n);
        check("not_latency", 32'(n), SKIP ? 32'd2 : 32'd3);
        check("not_C", 32'(C), 32'h0000fffb);
        tick();
        check("not_R2", 32'(dut.u_rf.regs_q[2]), 32'h0000fffb);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
